// File: rtl/punc_defs.sv
// Shared encodings for the PUnC LC3 control unit and datapath.
// State enum, opcodes, select encodings and the control bundle.
package punc_defs;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_EXEC2  = 3'd3,
    S_HALT   = 3'd4
  } state_t;

  localparam logic [3:0] OP_BR   = 4'b0000;
  localparam logic [3:0] OP_ADD  = 4'b0001;
  localparam logic [3:0] OP_LD   = 4'b0010;
  localparam logic [3:0] OP_ST   = 4'b0011;
  localparam logic [3:0] OP_JSR  = 4'b0100;
  localparam logic [3:0] OP_AND  = 4'b0101;
  localparam logic [3:0] OP_LDR  = 4'b0110;
  localparam logic [3:0] OP_STR  = 4'b0111;
  localparam logic [3:0] OP_RTI  = 4'b1000;
  localparam logic [3:0] OP_NOT  = 4'b1001;
  localparam logic [3:0] OP_LDI  = 4'b1010;
  localparam logic [3:0] OP_STI  = 4'b1011;
  localparam logic [3:0] OP_JMP  = 4'b1100;
  localparam logic [3:0] OP_RSV  = 4'b1101;
  localparam logic [3:0] OP_LEA  = 4'b1110;
  localparam logic [3:0] OP_HALT = 4'b1111;

  localparam logic [1:0] PC_SEL_OFF9  = 2'd0;
  localparam logic [1:0] PC_SEL_OFF11 = 2'd1;
  localparam logic [1:0] PC_SEL_REG   = 2'd2;

  localparam logic [1:0] MADDR_PC  = 2'd0;
  localparam logic [1:0] MADDR_ALU = 2'd1;
  localparam logic [1:0] MADDR_MAR = 2'd2;

  localparam logic [1:0] WDATA_ALU = 2'd0;
  localparam logic [1:0] WDATA_MEM = 2'd1;
  localparam logic [1:0] WDATA_PC  = 2'd2;

  localparam logic [1:0] ALU_ADD  = 2'd0;
  localparam logic [1:0] ALU_AND  = 2'd1;
  localparam logic [1:0] ALU_NOT  = 2'd2;
  localparam logic [1:0] ALU_PASS = 2'd3;

  localparam logic [1:0] EXT_IMM5  = 2'd0;
  localparam logic [1:0] EXT_OFF6  = 2'd1;
  localparam logic [1:0] EXT_OFF9  = 2'd2;
  localparam logic [1:0] EXT_OFF11 = 2'd3;

  localparam logic WADDR_IR = 1'b0;
  localparam logic WADDR_R7 = 1'b1;

  localparam logic RADDR1_SR  = 1'b0;
  localparam logic RADDR1_DST = 1'b1;

  localparam logic OP1_REG = 1'b0;
  localparam logic OP1_PC  = 1'b1;

  localparam logic OP2_REG = 1'b0;
  localparam logic OP2_EXT = 1'b1;

  typedef struct packed {
    logic       ir_ld;
    logic       pc_inc;
    logic       pc_ld;
    logic [1:0] pc_sel;
    logic       mar_ld;
    logic [1:0] mem_addr_sel;
    logic       mem_w_en;
    logic       rf_w_en;
    logic       rf_waddr_sel;
    logic       rf_raddr1_sel;
    logic [1:0] rf_wdata_sel;
    logic [1:0] alu_op;
    logic       op1_sel;
    logic       op2_sel;
    logic [1:0] ext_sel;
    logic       cc_ld;
    logic       halted;
  } ctrl_t;

  localparam ctrl_t CTRL_IDLE = '0;

  function automatic logic br_taken(
    input logic [2:0] nzp,
    input logic       n,
    input logic       z,
    input logic       p
  );
    return (nzp[2] & n) | (nzp[1] & z) | (nzp[0] & p);
  endfunction

endpackage

// File: rtl/punc_control.sv
// PUnC LC3 control unit: Moore FSM sequencing FETCH/DECODE/EXEC.
// Drives every datapath load, select and write enable.
module punc_control
  import punc_defs::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] opcode,
  input  logic [2:0] ir_11_9,
  input  logic       ir_5,
  input  logic       cc_n,
  input  logic       cc_z,
  input  logic       cc_p,
  output logic       ir_ld,
  output logic       pc_inc,
  output logic       pc_ld,
  output logic [1:0] pc_sel,
  output logic       mar_ld,
  output logic [1:0] mem_addr_sel,
  output logic       mem_w_en,
  output logic       rf_w_en,
  output logic       rf_waddr_sel,
  output logic       rf_raddr1_sel,
  output logic [1:0] rf_wdata_sel,
  output logic [1:0] alu_op,
  output logic       op1_sel,
  output logic       op2_sel,
  output logic [1:0] ext_sel,
  output logic       cc_ld,
  output logic       halted
);

  state_t state;
  state_t state_nx;
  ctrl_t  ctrl;
  ctrl_t  ctrl_q;

  // State register; reset lands in FETCH from any state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_FETCH;
    else     state <= state_nx;
  end

  // Next-state logic.
  always_comb begin
    state_nx = state;
    unique case (state)
      S_FETCH:  state_nx = S_DECODE;
      S_DECODE: begin
        if (opcode == OP_HALT) state_nx = S_HALT;
        else                   state_nx = S_EXEC;
      end
      S_EXEC: begin
        if (opcode == OP_LDI || opcode == OP_STI)
          state_nx = S_EXEC2;
        else
          state_nx = S_FETCH;
      end
      S_EXEC2:  state_nx = S_FETCH;
      S_HALT:   state_nx = S_HALT;
      default:  state_nx = S_FETCH;
    endcase
  end

  // Output decoder: per-state, per-opcode datapath controls.
  always_comb begin
    ctrl = CTRL_IDLE;
    unique case (state)
      S_FETCH: begin
        ctrl.mem_addr_sel = MADDR_PC;
        ctrl.ir_ld        = 1'b1;
        ctrl.pc_inc       = 1'b1;
      end
      S_DECODE: ;
      S_EXEC: begin
        unique case (opcode)
          OP_ADD, OP_AND: begin
            ctrl.alu_op   = (opcode == OP_ADD) ? ALU_ADD : ALU_AND;
            ctrl.op1_sel  = OP1_REG;
            ctrl.op2_sel  = ir_5 ? OP2_EXT : OP2_REG;
            ctrl.ext_sel  = EXT_IMM5;
            ctrl.rf_raddr1_sel = RADDR1_SR;
            ctrl.rf_wdata_sel  = WDATA_ALU;
            ctrl.rf_w_en  = 1'b1;
            ctrl.cc_ld    = 1'b1;
          end
          OP_NOT: begin
            ctrl.alu_op   = ALU_NOT;
            ctrl.op1_sel  = OP1_REG;
            ctrl.rf_wdata_sel = WDATA_ALU;
            ctrl.rf_w_en  = 1'b1;
            ctrl.cc_ld    = 1'b1;
          end
          OP_BR: begin
            ctrl.pc_sel = PC_SEL_OFF9;
            ctrl.pc_ld  = br_taken(ir_11_9, cc_n, cc_z, cc_p);
          end
          OP_JMP: begin
            ctrl.pc_sel = PC_SEL_REG;
            ctrl.pc_ld  = 1'b1;
          end
          OP_JSR: begin
            // Link and jump together: the old base is read this cycle.
            ctrl.rf_w_en      = 1'b1;
            ctrl.rf_waddr_sel = WADDR_R7;
            ctrl.rf_wdata_sel = WDATA_PC;
            ctrl.pc_sel = ir_11_9[2] ? PC_SEL_OFF11 : PC_SEL_REG;
            ctrl.pc_ld  = 1'b1;
          end
          OP_LD, OP_LDR: begin
            ctrl.mem_addr_sel = MADDR_ALU;
            ctrl.alu_op  = ALU_ADD;
            ctrl.op1_sel = (opcode == OP_LD) ? OP1_PC : OP1_REG;
            ctrl.op2_sel = OP2_EXT;
            ctrl.ext_sel = (opcode == OP_LD) ? EXT_OFF9 : EXT_OFF6;
            ctrl.rf_wdata_sel = WDATA_MEM;
            ctrl.rf_w_en = 1'b1;
            ctrl.cc_ld   = 1'b1;
          end
          OP_LEA: begin
            ctrl.alu_op  = ALU_ADD;
            ctrl.op1_sel = OP1_PC;
            ctrl.op2_sel = OP2_EXT;
            ctrl.ext_sel = EXT_OFF9;
            ctrl.rf_wdata_sel = WDATA_ALU;
            ctrl.rf_w_en = 1'b1;
            ctrl.cc_ld   = 1'b1;
          end
          OP_ST, OP_STR: begin
            ctrl.mem_addr_sel = MADDR_ALU;
            ctrl.alu_op  = ALU_ADD;
            ctrl.op1_sel = (opcode == OP_ST) ? OP1_PC : OP1_REG;
            ctrl.op2_sel = OP2_EXT;
            ctrl.ext_sel = (opcode == OP_ST) ? EXT_OFF9 : EXT_OFF6;
            ctrl.rf_raddr1_sel = RADDR1_DST;
            ctrl.mem_w_en = 1'b1;
          end
          OP_LDI, OP_STI: begin
            // First hop: fetch the pointer into MAR.
            ctrl.mem_addr_sel = MADDR_ALU;
            ctrl.alu_op  = ALU_ADD;
            ctrl.op1_sel = OP1_PC;
            ctrl.op2_sel = OP2_EXT;
            ctrl.ext_sel = EXT_OFF9;
            ctrl.mar_ld  = 1'b1;
          end
          OP_RTI, OP_RSV, OP_HALT: ;
          default: ;
        endcase
      end
      S_EXEC2: begin
        ctrl.mem_addr_sel = MADDR_MAR;
        if (opcode == OP_LDI) begin
          ctrl.rf_wdata_sel = WDATA_MEM;
          ctrl.rf_w_en = 1'b1;
          ctrl.cc_ld   = 1'b1;
        end else if (opcode == OP_STI) begin
          ctrl.rf_raddr1_sel = RADDR1_DST;
          ctrl.mem_w_en = 1'b1;
        end
      end
      S_HALT: ctrl.halted = 1'b1;
      default: ;
    endcase
  end

  // Reset forces every strobe low at once, even mid-instruction.
  always_comb begin
    ctrl_q = ctrl;
    if (rst) ctrl_q = CTRL_IDLE;
  end

  assign ir_ld         = ctrl_q.ir_ld;
  assign pc_inc        = ctrl_q.pc_inc;
  assign pc_ld         = ctrl_q.pc_ld;
  assign pc_sel        = ctrl_q.pc_sel;
  assign mar_ld        = ctrl_q.mar_ld;
  assign mem_addr_sel  = ctrl_q.mem_addr_sel;
  assign mem_w_en      = ctrl_q.mem_w_en;
  assign rf_w_en       = ctrl_q.rf_w_en;
  assign rf_waddr_sel  = ctrl_q.rf_waddr_sel;
  assign rf_raddr1_sel = ctrl_q.rf_raddr1_sel;
  assign rf_wdata_sel  = ctrl_q.rf_wdata_sel;
  assign alu_op        = ctrl_q.alu_op;
  assign op1_sel       = ctrl_q.op1_sel;
  assign op2_sel       = ctrl_q.op2_sel;
  assign ext_sel       = ctrl_q.ext_sel;
  assign cc_ld         = ctrl_q.cc_ld;
  assign halted        = ctrl_q.halted;

endmodule

// File: tb/tb_punc_control.sv
// Directed bench for punc_control.
// One task per scenario, expected values written by hand.
module tb_punc_control;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] opcode = 4'b0001;
  logic [2:0] ir_11_9 = 3'b000;
  logic       ir_5 = 1'b0;
  logic       cc_n = 1'b0;
  logic       cc_z = 1'b0;
  logic       cc_p = 1'b0;
  logic       ir_ld, pc_inc, pc_ld, mar_ld, mem_w_en;
  logic       rf_w_en, rf_waddr_sel, rf_raddr1_sel;
  logic       op1_sel, op2_sel, cc_ld, halted;
  logic [1:0] pc_sel, mem_addr_sel, rf_wdata_sel;
  logic [1:0] alu_op, ext_sel;
  logic [21:0] outs;

  int pass_cnt = 0;
  int total = 0;

  punc_control dut (
    .clk(clk), .rst(rst), .opcode(opcode),
    .ir_11_9(ir_11_9), .ir_5(ir_5),
    .cc_n(cc_n), .cc_z(cc_z), .cc_p(cc_p),
    .ir_ld(ir_ld), .pc_inc(pc_inc), .pc_ld(pc_ld),
    .pc_sel(pc_sel), .mar_ld(mar_ld),
    .mem_addr_sel(mem_addr_sel), .mem_w_en(mem_w_en),
    .rf_w_en(rf_w_en), .rf_waddr_sel(rf_waddr_sel),
    .rf_raddr1_sel(rf_raddr1_sel),
    .rf_wdata_sel(rf_wdata_sel), .alu_op(alu_op),
    .op1_sel(op1_sel), .op2_sel(op2_sel),
    .ext_sel(ext_sel), .cc_ld(cc_ld), .halted(halted)
  );

  always #5 clk = ~clk;

  assign outs = {ir_ld, pc_inc, pc_ld, pc_sel, mar_ld,
                 mem_addr_sel, mem_w_en, rf_w_en,
                 rf_waddr_sel, rf_raddr1_sel, rf_wdata_sel,
                 alu_op, op1_sel, op2_sel, ext_sel,
                 cc_ld, halted};

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic test_reset();
    repeat (2) tick();
    total++;
    if (outs !== 22'd0)
      $display("FAIL reset_outs got=%h exp=0", outs);
    else pass_cnt++;
    opcode = 4'b0001; ir_11_9 = 3'b001; ir_5 = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    total++;
    if ({ir_ld, pc_inc, mem_addr_sel} !== 4'b1100)
      $display("FAIL first_fetch got=%b exp=1100",
               {ir_ld, pc_inc, mem_addr_sel});
    else pass_cnt++;
  endtask

  task automatic test_add();
    tick();
    total++;
    if (outs !== 22'd0)
      $display("FAIL add_decode got=%h exp=0", outs);
    else pass_cnt++;
    tick();
    total++;
    if ({rf_w_en, op2_sel, ext_sel, alu_op, cc_ld, op1_sel,
         rf_wdata_sel, mem_w_en, pc_ld} !== 12'b1_1_00_00_1_0_00_0_0)
      $display("FAIL add_exec got=%b exp=110000100000",
               {rf_w_en, op2_sel, ext_sel, alu_op, cc_ld, op1_sel,
                rf_wdata_sel, mem_w_en, pc_ld});
    else pass_cnt++;
    tick();
    total++;
    if (ir_ld !== 1'b1)
      $display("FAIL add_next_fetch got=%b exp=1", ir_ld);
    else pass_cnt++;
  endtask

  task automatic test_and_reg();
    opcode = 4'b0101; ir_5 = 1'b0;
    tick(); tick();
    total++;
    if ({rf_w_en, op2_sel, alu_op, cc_ld} !== 5'b1_0_01_1)
      $display("FAIL and_reg got=%b exp=10011",
               {rf_w_en, op2_sel, alu_op, cc_ld});
    else pass_cnt++;
    tick();
  endtask

  task automatic test_br();
    opcode = 4'b0000; ir_11_9 = 3'b010;
    cc_z = 1'b1;
    tick(); tick();
    total++;
    if ({pc_ld, pc_sel, rf_w_en} !== 4'b1_00_0)
      $display("FAIL br_taken got=%b exp=1000",
               {pc_ld, pc_sel, rf_w_en});
    else pass_cnt++;
    cc_z = 1'b0; cc_p = 1'b1;
    #1;
    total++;
    if (pc_ld !== 1'b0)
      $display("FAIL br_not_taken got=%b exp=0", pc_ld);
    else pass_cnt++;
    cc_p = 1'b0;
    tick();
  endtask

  task automatic test_ldi();
    opcode = 4'b1010; ir_11_9 = 3'b001;
    tick(); tick();
    total++;
    if ({mar_ld, mem_addr_sel, op1_sel, ext_sel, rf_w_en}
        !== 7'b1_01_1_10_0)
      $display("FAIL ldi_exec got=%b exp=1011100",
               {mar_ld, mem_addr_sel, op1_sel, ext_sel, rf_w_en});
    else pass_cnt++;
    tick();
    total++;
    if ({rf_wdata_sel, mem_addr_sel, rf_w_en, cc_ld, mar_ld}
        !== 7'b01_10_1_1_0)
      $display("FAIL ldi_exec2 got=%b exp=0110110",
               {rf_wdata_sel, mem_addr_sel, rf_w_en, cc_ld, mar_ld});
    else pass_cnt++;
    tick();
    total++;
    if (ir_ld !== 1'b1)
      $display("FAIL ldi_next_fetch got=%b exp=1", ir_ld);
    else pass_cnt++;
  endtask

  task automatic test_jsr();
    opcode = 4'b0100; ir_11_9 = 3'b100;
    tick(); tick();
    total++;
    if ({rf_w_en, rf_waddr_sel, rf_wdata_sel, pc_sel, pc_ld}
        !== 7'b1_1_10_01_1)
      $display("FAIL jsr_exec got=%b exp=1110011",
               {rf_w_en, rf_waddr_sel, rf_wdata_sel, pc_sel, pc_ld});
    else pass_cnt++;
    ir_11_9 = 3'b000;
    #1;
    total++;
    if ({pc_sel, pc_ld} !== 3'b10_1)
      $display("FAIL jsrr_exec got=%b exp=101", {pc_sel, pc_ld});
    else pass_cnt++;
    tick();
  endtask

  task automatic test_str();
    opcode = 4'b0111; ir_11_9 = 3'b011;
    tick(); tick();
    total++;
    if ({mem_w_en, rf_raddr1_sel, mem_addr_sel, op1_sel, ext_sel,
         rf_w_en} !== 8'b1_1_01_0_01_0)
      $display("FAIL str_exec got=%b exp=11010010",
               {mem_w_en, rf_raddr1_sel, mem_addr_sel, op1_sel,
                ext_sel, rf_w_en});
    else pass_cnt++;
    tick();
  endtask

  task automatic test_sti_reset();
    opcode = 4'b1011;
    tick(); tick(); tick();
    total++;
    if ({mem_w_en, rf_raddr1_sel, mem_addr_sel} !== 4'b1_1_10)
      $display("FAIL sti_exec2 got=%b exp=1110",
               {mem_w_en, rf_raddr1_sel, mem_addr_sel});
    else pass_cnt++;
    rst = 1'b1;
    #1;
    total++;
    if (outs !== 22'd0)
      $display("FAIL sti_rst_drop got=%h exp=0", outs);
    else pass_cnt++;
    opcode = 4'b0001;
    tick();
    @(negedge clk);
    rst = 1'b0;
    #1;
    total++;
    if ({ir_ld, pc_inc} !== 2'b11)
      $display("FAIL sti_resume got=%b exp=11", {ir_ld, pc_inc});
    else pass_cnt++;
  endtask

  task automatic test_halt();
    opcode = 4'b1111;
    tick();
    total++;
    if (halted !== 1'b0)
      $display("FAIL halt_decode got=%b exp=0", halted);
    else pass_cnt++;
    tick();
    for (int i = 0; i < 12; i++) begin
      total++;
      if (outs !== 22'd1)
        $display("FAIL halt_hold cyc=%0d got=%h exp=1", i, outs);
      else pass_cnt++;
      tick();
    end
    rst = 1'b1;
    #1;
    total++;
    if (outs !== 22'd0)
      $display("FAIL halt_rst got=%h exp=0", outs);
    else pass_cnt++;
    opcode = 4'b0001;
    @(negedge clk);
    rst = 1'b0;
    #1;
    total++;
    if ({ir_ld, halted} !== 2'b10)
      $display("FAIL halt_restart got=%b exp=10", {ir_ld, halted});
    else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_add();
    test_and_reg();
    test_br();
    test_ldi();
    test_jsr();
    test_str();
    test_sti_reset();
    test_halt();
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/punc_control.md
# punc_control

Control unit for the PUnC LC3 processor. It sits directly upstream of the PUnC datapath and is a Moore-style state machine. It consumes the datapath's opcode, selected IR fields and registered condition codes, and drives every datapath load, select and write-enable. Each instruction is sequenced as FETCH → DECODE → EXEC, with a second execute cycle for the indirect memory ops. HALT stops the processor until reset.

## Interface
Parameters:
- None; all encodings come from the shared package.

Ports:
- clk  in  1  processor clock
- rst  in  1  reset, asynchronous, active-high
- opcode  in  4  IR[15:12]
- ir_11_9  in  3  IR[11:9]: BR nzp mask; bit 2 is the JSR/JSRR select
- ir_5  in  1  IR[5]: ADD/AND immediate select
- cc_n, cc_z, cc_p  in  1 each  datapath condition-code register
- ir_ld  out  1  load IR from memory read port 0
- pc_inc  out  1  PC <= PC+1
- pc_ld  out  1  PC <= pc_sel source
- pc_sel  out  2  0 PC+off9, 1 PC+off11, 2 r_data_0
- mar_ld  out  1  MAR <= memory read data
- mem_addr_sel  out  2  0 PC, 1 ALU sum, 2 MAR
- mem_w_en  out  1  memory write; data is r_data_1
- rf_w_en  out  1  register write
- rf_waddr_sel  out  1  0 IR[11:9], 1 R7
- rf_raddr1_sel  out  1  0 IR[2:0], 1 IR[11:9]
- rf_wdata_sel  out  2  0 ALU, 1 memory data, 2 PC
- alu_op  out  2  0 ADD, 1 AND, 2 NOT(op1), 3 PASS(op2)
- op1_sel  out  1  0 r_data_0 (r_addr_0 = IR[8:6]), 1 PC
- op2_sel  out  1  0 r_data_1, 1 sign-extended field
- ext_sel  out  2  0 imm5, 1 off6, 2 off9, 3 off11
- cc_ld  out  1  load n/z/p from register write data
- halted  out  1  processor in HALT

## Operation
States: FETCH, DECODE, EXEC, EXEC2, HALT. State register is `state`.
- **FETCH**: mem_addr_sel=0, ir_ld=1, pc_inc=1 → DECODE.
- **DECODE**: all outputs idle.
  - Opcode 1111 → HALT.
  - Otherwise → EXEC.
- **EXEC**: per opcode, then → FETCH. Exceptions: LDI/STI → EXEC2.
  - ADD/AND: ALU op; op2 = imm5 if ir_5 else r_data_1; rf_w_en, cc_ld.
  - NOT: alu_op=2; rf_w_en, cc_ld.
  - BR: pc_ld with pc_sel=0 only when taken.
    - Taken = (ir_11_9[2]&cc_n)|(ir_11_9[1]&cc_z)|(ir_11_9[0]&cc_p).
  - JMP/RET: pc_sel=2, pc_ld.
  - JSR/JSRR: rf_w_en, rf_waddr_sel=1, rf_wdata_sel=2; pc_ld with pc_sel=1 if ir_11_9[2] else 2.
  - LD/LDR: address = PC+off9 or r_data_0+off6 (mem_addr_sel=1); rf_wdata_sel=1, rf_w_en, cc_ld.
  - LEA: op1=PC, off9, alu_op=0; rf_w_en, cc_ld.
  - ST/STR: same address generation as LD/LDR; rf_raddr1_sel=1, mem_w_en.
  - LDI/STI: PC+off9 address, mar_ld.
  - Opcodes 1000, 1101: no action (NOP).
- **EXEC2**: mem_addr_sel=2.
  - LDI: rf_w_en, rf_wdata_sel=1, cc_ld.
  - STI: rf_raddr1_sel=1, mem_w_en.
  - Then → FETCH.
- **HALT**: halted=1, all other outputs 0; remains in HALT until rst.

## Timing
- While rst is high: state=FETCH and every output is 0, including ir_ld and halted.
- First FETCH strobe occurs in the first cycle after rst deasserts.
- Instruction latency:
  - 3 cycles for most opcodes.
  - 4 cycles for LDI/STI.
  - 2 cycles to reach HALT.
- PC already holds PC+1 in EXEC, so all PC-relative offsets and the JSR link value use the incremented PC.
- BR evaluates cc_* combinationally in EXEC, i.e. flags from the previous instruction's write.
- JSRR with BaseR=R7: the old R7 is read and R7 is written in the same cycle; the jump uses the old R7.
- Asynchronous reset in any state, including mid-EXEC2, returns the FSM to FETCH immediately. No partial write is issued after rst asserts.

## Structure
- Shared package `punc_defs`: state enum, opcode constants, pc_sel / mem_addr_sel / rf_wdata_sel / alu_op / ext_sel encodings.
- The datapath imports the same package.
- No sub-module: one state register plus one combinational output decoder.

## Test plan
- ADD R1,R1,#3 (0x1263) after reset → ir_ld in cycle 1; in cycle 3: rf_w_en=1, op2_sel=1, ext_sel=0, alu_op=0, cc_ld=1.
- BRz (0x0405) with cc_z=1 → pc_ld=1, pc_sel=0 in EXEC; with cc_z=0 → pc_ld=0.
- LDI (0xA201) → EXEC: mar_ld=1, mem_addr_sel=1; EXEC2: rf_wdata_sel=1, mem_addr_sel=2; next cycle FETCH.
- JSR (0x4802) → in EXEC: rf_waddr_sel=1, rf_wdata_sel=2, pc_sel=1, pc_ld=1 simultaneously.
- HALT (0xF025) → halted=1 from cycle 3 and held for ≥10 cycles with no strobes; rst then clears halted and restarts FETCH.
- Assert rst mid-EXEC2 of STI → mem_w_en drops the same cycle; FETCH resumes after release.
